// File: rtl/rnd_target_gen.sv
// Random target generator for the snake playfield.
// A 16-bit Galois LFSR supplies one candidate {x,y} per cycle. Candidates
// that fall outside the playfield or on the snake head are rejected. After
// MAX_TRIES rejected draws, a deterministic fallback position is used.
// The accepted target is held until the snake eats it.
//
// Handshake: TARGET_VALID is high exactly while the FSM is in HOLD and
// RND_ADDR is a settled target. TARGET_ATE acts only when sampled high at a
// clock edge while TARGET_VALID is high; that edge consumes the target.
// TARGET_ATE during DRAW is dropped, not queued.
module rnd_target_gen #(
    parameter int          X_BITS     = 8,
    parameter int          Y_BITS     = 7,
    parameter int          X_MAX      = 159,
    parameter int          Y_MAX      = 119,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          MAX_TRIES  = 16,
    parameter int          COUNT_BITS = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       TARGET_ATE,
    input  logic [X_BITS+Y_BITS-1:0]   SNAKE_HEAD,
    output logic [X_BITS+Y_BITS-1:0]   RND_ADDR,
    output logic                       TARGET_VALID,
    output logic                       FALLBACK_USED,
    output logic [COUNT_BITS-1:0]      TARGET_COUNT,
    output logic                       dbg_state
);

    localparam int A_BITS   = X_BITS + Y_BITS;
    localparam int TRY_BITS = $clog2(MAX_TRIES + 1);

    localparam logic [X_BITS-1:0]   X_LIM    = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0]   Y_LIM    = Y_BITS'(Y_MAX);
    localparam logic [TRY_BITS-1:0] LAST_TRY = TRY_BITS'(MAX_TRIES - 1);
    localparam logic [A_BITS-1:0]   CENTRE   = {X_BITS'(X_MAX >> 1), Y_BITS'(Y_MAX >> 1)};
    localparam logic [15:0]         LFSR_MASK = 16'hB400;

    typedef enum logic {
        DRAW = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q;
    logic [TRY_BITS-1:0]   tries_q, tries_d;
    logic [A_BITS-1:0]     addr_q, addr_d;
    logic                  fb_q, fb_d;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic [X_BITS-1:0]     cand_x;
    logic [Y_BITS-1:0]     cand_y;
    logic [A_BITS-1:0]     cand;
    logic                  reject;
    logic [A_BITS-1:0]     fallback;

    // Candidate comes straight from the current LFSR value: x from the low
    // bits, y from the top bits.
    assign cand_x   = lfsr_q[X_BITS-1:0];
    assign cand_y   = lfsr_q[15 -: Y_BITS];
    assign cand     = {cand_x, cand_y};
    assign reject   = (cand_x > X_LIM) || (cand_y > Y_LIM) || (cand == SNAKE_HEAD);
    // The centre of the field, unless the head sits there; then the origin.
    assign fallback = (CENTRE == SNAKE_HEAD) ? '0 : CENTRE;

    // The LFSR free-runs in every state; a nonzero seed keeps it off zero.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= DRAW;
            tries_q <= '0;
            addr_q  <= '0;
            fb_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            addr_q  <= addr_d;
            fb_q    <= fb_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: draw, retry or fall back in DRAW; wait for the eat in HOLD.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        addr_d  = addr_q;
        fb_d    = fb_q;
        count_d = count_q;
        unique case (state_q)
            DRAW: begin
                if (!reject) begin
                    addr_d  = cand;
                    fb_d    = 1'b0;
                    state_d = HOLD;
                end else if (tries_q == LAST_TRY) begin
                    addr_d  = fallback;
                    fb_d    = 1'b1;
                    state_d = HOLD;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            HOLD: begin
                if (TARGET_ATE) begin
                    state_d = DRAW;
                    tries_d = '0;
                    if (count_q != {COUNT_BITS{1'b1}}) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = DRAW;
            end
        endcase
    end

    assign RND_ADDR      = addr_q;
    assign TARGET_VALID  = (state_q == HOLD);
    assign FALLBACK_USED = fb_q;
    assign TARGET_COUNT  = count_q;
    assign dbg_state     = state_q;

endmodule
